// File: rtl/cgb_mmcm_drp_ctrl.sv
// -----------------------------------------------------------------------------
// cgb_mmcm_drp_ctrl
// Dynamic-reconfiguration master for the clock-generation MMCM. Each accepted
// request performs one masked read-modify-write on the MMCM DRP port. The MMCM
// is held in reset for the whole burst (from the first accept until the last
// write completes), then released, and the controller waits for re-lock.
//
// Ports
//   iClk, iRst           base clock (also DRP DCLK), async active-high reset
//   iReq/oAck            request handshake; oAck is the accept pulse
//   iAddr/iData/iMask    register address, new bits, keep-mask (1 = keep)
//   iLast                marks the final register of a burst
//   oBusy                high while a burst is in flight
//   oDone/oErr           1-cycle completion / abort pulses
//   oErrCode             abort reason, held until the next accept
//   oDaddr/oDi/oDen/oDwe DRP request (all registered, aligned with oDen)
//   iDo/iDrdy            DRP response
//   oMmcmRst             MMCM reset
//   iLocked              MMCM lock, asynchronous to iClk
// -----------------------------------------------------------------------------
module cgb_mmcm_drp_ctrl #(
    parameter int pDrdyTimeout = 64,
    parameter int pLockTimeout = 1000000,
    parameter int pSyncStages  = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq,
    output logic        oAck,
    input  logic [6:0]  iAddr,
    input  logic [15:0] iData,
    input  logic [15:0] iMask,
    input  logic        iLast,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr,
    output logic [1:0]  oErrCode,
    output logic [6:0]  oDaddr,
    output logic [15:0] oDi,
    input  logic [15:0] iDo,
    output logic        oDen,
    output logic        oDwe,
    input  logic        iDrdy,
    output logic        oMmcmRst,
    input  logic        iLocked
);

    localparam int cTmax = (pDrdyTimeout > pLockTimeout) ? pDrdyTimeout : pLockTimeout;
    localparam int cTw   = $clog2(cTmax + 1);

    localparam logic [1:0] cErrNone = 2'd0;
    localparam logic [1:0] cErrRd   = 2'd1;
    localparam logic [1:0] cErrWr   = 2'd2;
    localparam logic [1:0] cErrLock = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ON,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_NEXT,
        S_REL,
        S_LOCK_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic [15:0]            mask_q, mask_d;
    logic                   last_q, last_d;
    logic [15:0]            rmw_q, rmw_d;
    logic [cTw-1:0]         timer_q, timer_d;
    logic [1:0]             code_q, code_d;
    logic [pSyncStages-1:0] sync_q;
    logic                   wLockS;

    // Registered output stage, computed from the next state so every DRP
    // field is valid in exactly the cycle its state is active.
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        mrst_q, mrst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ack;

    assign wLockS = sync_q[pSyncStages-1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        last_d  = last_q;
        rmw_d   = rmw_q;
        code_d  = code_q;
        ack     = 1'b0;
        // Saturate rather than wrap so a stuck wait can never alias to a
        // fresh count.
        timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                ack = iReq;
                if (iReq) begin
                    addr_d  = iAddr;
                    data_d  = iData;
                    mask_d  = iMask;
                    last_d  = iLast;
                    code_d  = cErrNone;
                    state_d = S_RST_ON;
                end
            end
            S_RST_ON: state_d = S_RD_REQ;
            S_RD_REQ: begin
                timer_d = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // A response in the final wait cycle still wins.
                if (iDrdy) begin
                    rmw_d   = (iDo & mask_q) | (data_q & ~mask_q);
                    state_d = S_WR_REQ;
                end else if (timer_q >= cTw'(pDrdyTimeout - 1)) begin
                    code_d  = cErrRd;
                    state_d = S_ERR;
                end
            end
            S_WR_REQ: begin
                timer_d = '0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (iDrdy) begin
                    state_d = last_q ? S_REL : S_NEXT;
                end else if (timer_q >= cTw'(pDrdyTimeout - 1)) begin
                    code_d  = cErrWr;
                    state_d = S_ERR;
                end
            end
            S_NEXT: begin
                // MMCM stays in reset; the next register goes straight to read.
                ack = iReq;
                if (iReq) begin
                    addr_d  = iAddr;
                    data_d  = iData;
                    mask_d  = iMask;
                    last_d  = iLast;
                    state_d = S_RD_REQ;
                end
            end
            S_REL: begin
                timer_d = '0;
                state_d = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                if (wLockS) begin
                    state_d = S_DONE;
                end else if (timer_q >= cTw'(pLockTimeout - 1)) begin
                    code_d  = cErrLock;
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        den_d   = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        dwe_d   = (state_d == S_WR_REQ);
        daddr_d = den_d ? addr_d : '0;
        di_d    = dwe_d ? rmw_d : '0;
        mrst_d  = (state_d == S_RST_ON)  || (state_d == S_RD_REQ)  ||
                  (state_d == S_RD_WAIT) || (state_d == S_WR_REQ)  ||
                  (state_d == S_WR_WAIT) || (state_d == S_NEXT);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            rmw_q   <= '0;
            timer_q <= '0;
            code_q  <= '0;
            sync_q  <= '0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
            mrst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            rmw_q   <= rmw_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            sync_q  <= {sync_q[pSyncStages-2:0], iLocked};
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            mrst_q  <= mrst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The accept strobe is combinational; mask it so reset forces it low too.
    assign oAck     = ack & ~iRst;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oErr     = err_q;
    assign oErrCode = code_q;
    assign oDaddr   = daddr_q;
    assign oDi      = di_q;
    assign oDen     = den_q;
    assign oDwe     = dwe_q;
    assign oMmcmRst = mrst_q;

endmodule

// File: tb/tb_cgb_mmcm_drp_ctrl.sv
// Bench for cgb_mmcm_drp_ctrl. A DRP register-file responder and an MMCM lock
// generator react to the DUT; a transaction-level model predicts the DRP
// accesses and burst outcomes, and a compare process checks every cycle.
// Instance A uses default parameters, instance B a short lock timeout; the
// one not under test is held in reset.
module tb_cgb_mmcm_drp_ctrl;
    logic        iClk = 1'b0;
    logic        rst = 1'b1, sel = 1'b0;
    logic        rst_a, rst_b;
    logic        iReq = 1'b0, iLast = 1'b0;
    logic [6:0]  iAddr = '0;
    logic [15:0] iData = '0, iMask = '0, iDo = 16'hDEAD;
    logic        iDrdy = 1'b0, iLocked = 1'b0;

    logic        a_ack, a_busy, a_done, a_err, a_den, a_dwe, a_mrst;
    logic [1:0]  a_code;
    logic [6:0]  a_daddr;
    logic [15:0] a_di;
    logic        b_ack, b_busy, b_done, b_err, b_den, b_dwe, b_mrst;
    logic [1:0]  b_code;
    logic [6:0]  b_daddr;
    logic [15:0] b_di;
    logic        s_ack, s_busy, s_done, s_err, s_den, s_dwe, s_mrst;
    logic [1:0]  s_code;
    logic [6:0]  s_daddr;
    logic [15:0] s_di;

    assign rst_a = rst | sel;
    assign rst_b = rst | ~sel;

    always #5 iClk = ~iClk;

    cgb_mmcm_drp_ctrl dut_a (
        .iClk(iClk), .iRst(rst_a), .iReq(iReq), .oAck(a_ack), .iAddr(iAddr),
        .iData(iData), .iMask(iMask), .iLast(iLast), .oBusy(a_busy), .oDone(a_done),
        .oErr(a_err), .oErrCode(a_code), .oDaddr(a_daddr), .oDi(a_di), .iDo(iDo),
        .oDen(a_den), .oDwe(a_dwe), .iDrdy(iDrdy), .oMmcmRst(a_mrst), .iLocked(iLocked));

    cgb_mmcm_drp_ctrl #(.pLockTimeout(100)) dut_b (
        .iClk(iClk), .iRst(rst_b), .iReq(iReq), .oAck(b_ack), .iAddr(iAddr),
        .iData(iData), .iMask(iMask), .iLast(iLast), .oBusy(b_busy), .oDone(b_done),
        .oErr(b_err), .oErrCode(b_code), .oDaddr(b_daddr), .oDi(b_di), .iDo(iDo),
        .oDen(b_den), .oDwe(b_dwe), .iDrdy(iDrdy), .oMmcmRst(b_mrst), .iLocked(iLocked));

    assign s_ack   = sel ? b_ack   : a_ack;
    assign s_busy  = sel ? b_busy  : a_busy;
    assign s_done  = sel ? b_done  : a_done;
    assign s_err   = sel ? b_err   : a_err;
    assign s_code  = sel ? b_code  : a_code;
    assign s_daddr = sel ? b_daddr : a_daddr;
    assign s_di    = sel ? b_di    : a_di;
    assign s_den   = sel ? b_den   : a_den;
    assign s_dwe   = sel ? b_dwe   : a_dwe;
    assign s_mrst  = sel ? b_mrst  : a_mrst;

    typedef struct {
        logic        we;
        logic [6:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t        expq[$];     // expected DRP accesses in order
    int          outq[$];     // expected burst outcomes: 0 done, 1..3 error code
    logic [15:0] drp_mem[128];
    logic [15:0] exp_mem[128];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int rd_lat = 1, wr_lat = 1, lock_lat = 10;
    int n_rd = 0, n_wr = 0, n_rise = 0, n_ev = 0;
    int rd_den_cyc = 0, fall_cyc = 0, ev_cyc = 0, lock_cyc = 0;
    logic [15:0] last_wr_di = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge iClk);
        cyc++;
    end

    // DRP register file: latency in cycles after the DEN cycle, 0 = never answer.
    initial begin
        int  cnt;
        bit  pend;
        logic [15:0] pdo;
        pend = 0; cnt = 0; pdo = '0;
        forever begin
            @(posedge iClk); #1;
            iDrdy = 1'b0;
            iDo   = 16'hDEAD;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    iDrdy = 1'b1;
                    iDo   = pdo;
                    pend  = 0;
                end
            end
            if (s_den && !rst) begin
                if (s_dwe) drp_mem[s_daddr] = s_di;
                pdo = drp_mem[s_daddr];
                cnt = s_dwe ? wr_lat : rd_lat;
                pend = (cnt > 0);
            end
        end
    end

    // MMCM lock: rises lock_lat cycles after MMCM reset falls, drops with reset.
    initial begin
        int  lcnt;
        bit  armed;
        lcnt = 0; armed = 0;
        forever begin
            @(posedge iClk); #1;
            if (s_mrst) begin
                iLocked = 1'b0; armed = 1; lcnt = 0;
            end else if (armed) begin
                lcnt++;
                if (lock_lat != 0 && lcnt == lock_lat) begin
                    iLocked  = 1'b1;
                    lock_cyc = cyc;
                end
            end
        end
    end

    // Per-cycle comparison against the transaction model.
    initial begin
        bit   pm, pb;
        exp_t e;
        int   o;
        pm = 0; pb = 0;
        forever begin
            @(negedge iClk);
            if (rst) begin
                pm = 0; pb = 0;
            end else begin
                if (s_mrst && !pm) n_rise++;
                if (!s_mrst && pm) fall_cyc = cyc;
                chk("dwe_without_den", {31'd0, s_dwe & ~s_den}, 32'd0);
                if (s_den) begin
                    if (s_dwe) begin n_wr++; last_wr_di = s_di; end
                    else begin n_rd++; rd_den_cyc = cyc; end
                    if (expq.size() == 0) begin
                        chk("den_unexpected", {31'd0, s_den}, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("den_we", {31'd0, s_dwe}, {31'd0, e.we});
                        chk("den_addr", {25'd0, s_daddr}, {25'd0, e.a});
                        if (e.we) chk("wr_data", {16'd0, s_di}, {16'd0, e.d});
                        chk("mrst_during_drp", {31'd0, s_mrst}, 32'd1);
                    end
                end
                if (s_done || s_err) begin
                    n_ev++;
                    ev_cyc = cyc;
                    if (outq.size() == 0) begin
                        chk("end_unexpected", {30'd0, s_done, s_err}, 32'd0);
                    end else begin
                        o = outq.pop_front();
                        chk("end_kind", {28'd0, s_done, s_err, s_code},
                            (o == 0) ? 32'h8 : (32'h4 | o));
                        chk("busy_at_end", {31'd0, s_busy}, 32'd0);
                        chk("busy_before_end", {31'd0, pb}, 32'd1);
                        chk("mrst_at_end", {31'd0, s_mrst}, 32'd0);
                    end
                end
                pm = s_mrst;
                pb = s_busy;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // Issue one RMW; the model expectation is pushed at the accept cycle.
    task automatic rmw(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                       input logic last, input bit wr_ok);
        exp_t e;
        int   n;
        iAddr = a; iData = d; iMask = m; iLast = last; iReq = 1'b1;
        n = 0;
        forever begin
            @(negedge iClk);
            if (s_ack) break;
            n++;
            if (n > 3000) begin
                chk("ack_timeout", 32'd0, 32'd1);
                iReq = 1'b0;
                return;
            end
        end
        e.we = 1'b0; e.a = a; e.d = '0;
        expq.push_back(e);
        if (wr_ok) begin
            e.we = 1'b1;
            e.d  = (exp_mem[a] & m) | (d & ~m);
            exp_mem[a] = e.d;
            expq.push_back(e);
        end
        @(posedge iClk); #1;
        iReq = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int ev0;
        ev0 = n_ev;
        for (int i = 0; i < budget; i++) begin
            @(negedge iClk);
            if (n_ev != ev0) begin
                step(1);
                return;
            end
        end
        chk("end_timeout", 32'd0, 32'd1);
        step(1);
    endtask

    initial begin
        int r0, rd0, wr0, ev0;
        for (int i = 0; i < 128; i++) begin
            drp_mem[i] = 16'(i * 257) ^ 16'h5A5A;
            exp_mem[i] = drp_mem[i];
        end
        drp_mem[8] = 16'h1041;
        exp_mem[8] = 16'h1041;

        // Reset state of both instances.
        #3;
        chk("reset_outs_a", {a_ack, a_busy, a_done, a_err, a_code, a_daddr, a_di, a_den, a_dwe, a_mrst}, 32'd0);
        chk("reset_outs_b", {b_ack, b_busy, b_done, b_err, b_code, b_daddr, b_di, b_den, b_dwe, b_mrst}, 32'd0);
        step(3);
        rst = 1'b0;
        step(2);

        // Single RMW, lock 500 cycles after MMCM reset release.
        rd_lat = 2; wr_lat = 3; lock_lat = 500;
        outq.push_back(0);
        rmw(7'h08, 16'h0082, 16'hF000, 1'b1, 1);
        wait_end(2000);
        chk("single_wr_data", {16'd0, last_wr_di}, 32'h1082);
        chk("lock_to_done", ev_cyc - lock_cyc, 32'd3);

        // Burst of three, MMCM held in reset across all of them.
        rd_lat = 1; wr_lat = 2; lock_lat = 20;
        r0 = n_rise; rd0 = n_rd; wr0 = n_wr; ev0 = n_ev;
        outq.push_back(0);
        rmw(7'h09, 16'h00A5, 16'hFF00, 1'b0, 1);
        rmw(7'h0A, 16'hBEEF, 16'h0000, 1'b0, 1);
        rmw(7'h08, 16'h3300, 16'h00FF, 1'b1, 1);
        wait_end(500);
        chk("burst_mrst_rises", n_rise - r0, 32'd1);
        chk("burst_reads", n_rd - rd0, 32'd3);
        chk("burst_writes", n_wr - wr0, 32'd3);
        chk("burst_ends", n_ev - ev0, 32'd1);
        chk("burst_last_wr", {16'd0, last_wr_di}, 32'h3382);

        // Read DRDY never arrives.
        rd_lat = 0;
        outq.push_back(1);
        rmw(7'h10, 16'h1234, 16'h00FF, 1'b1, 0);
        wait_end(200);
        chk("rd_timeout_cycles", ev_cyc - rd_den_cyc, 32'd65);
        step(10);
        chk("err_code_hold", {30'd0, s_code}, 32'd1);

        // DRDY in the last permitted read-wait cycle still wins.
        rd_lat = 64; wr_lat = 1; lock_lat = 10;
        outq.push_back(0);
        rmw(7'h12, 16'hA5A5, 16'h0F0F, 1'b1, 1);
        chk("err_code_clear", {30'd0, s_code}, 32'd0);
        wait_end(300);

        // Write DRDY never arrives.
        rd_lat = 1; wr_lat = 0;
        outq.push_back(2);
        rmw(7'h13, 16'h0F0F, 16'hF0F0, 1'b1, 1);
        wait_end(200);

        // Reset during write wait, then a late DRDY.
        rd_lat = 1; wr_lat = 30; lock_lat = 10;
        wr0 = n_wr;
        rmw(7'h14, 16'h5555, 16'h0000, 1'b1, 1);
        for (int i = 0; i < 50 && n_wr == wr0; i++) step(1);
        step(3);
        #2;
        ev0 = n_ev;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {s_ack, s_busy, s_done, s_err, s_code, s_daddr, s_di, s_den, s_dwe, s_mrst}, 32'd0);
        step(2);
        rst = 1'b0;
        step(40);
        chk("no_end_after_rst", n_ev - ev0, 32'd0);
        chk("idle_after_rst", {31'd0, s_busy}, 32'd0);
        wr_lat = 2;
        outq.push_back(0);
        rmw(7'h15, 16'h0001, 16'hFFFE, 1'b1, 1);
        wait_end(300);

        // Lock never rises on the short-timeout instance.
        rst = 1'b1; sel = 1'b1; lock_lat = 0;
        step(2);
        rst = 1'b0;
        step(2);
        rd_lat = 1; wr_lat = 1;
        outq.push_back(3);
        rmw(7'h16, 16'h00F0, 16'hFF0F, 1'b1, 1);
        wait_end(400);
        chk("lock_timeout_cycles", ev_cyc - fall_cyc, 32'd101);

        step(5);
        chk("drp_queue_empty", expq.size(), 32'd0);
        chk("end_queue_empty", outq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cgb_mmcm_drp_ctrl.md
Name: cgb_mmcm_drp_ctrl

Overview:
- Dynamic-reconfiguration master for the clock-generation MMCM.
- Drives the MMCM DRP port with masked read-modify-write transactions.
- Holds the MMCM in reset for the whole reconfiguration burst, then waits for re-lock.
- Runs on the 100 MHz base clock (DCLK). Lets the video pipeline retarget pixel/TMDS clocks without re-configuring the FPGA.

Parameters:
- pDrdyTimeout, 64: max iClk cycles to wait for iDrdy after a DEN pulse.
- pLockTimeout, 1000000: max iClk cycles to wait for synchronized lock after releasing MMCM reset.
- pSyncStages, 2: flip-flop stages in the iLocked synchronizer (>=2).

Ports:
- iClk  in  1  base clock, also DRP DCLK
- iRst  in  1  asynchronous, active-high reset
- iReq  in  1  request valid: one register RMW
- oAck  out  1  request accepted; 1-cycle pulse in the cycle iReq is taken
- iAddr  in  7  DRP register address
- iData  in  16  new bit values
- iMask  in  16  1 = keep existing bit, 0 = take iData bit
- iLast  in  1  last register of burst; qualifies iReq
- oBusy  out  1  high from accept of first request until DONE/ERR exit
- oDone  out  1  1-cycle pulse: burst finished and MMCM locked
- oErr  out  1  1-cycle pulse: burst aborted
- oErrCode  out  2  0 none, 1 read DRDY timeout, 2 write DRDY timeout, 3 lock timeout; held until next accept
- oDaddr  out  7  DRP address
- oDi  out  16  DRP write data
- iDo  in  16  DRP read data
- oDen  out  1  DRP enable, 1-cycle pulse
- oDwe  out  1  DRP write enable, only with oDen
- iDrdy  in  1  DRP ready
- oMmcmRst  out  1  MMCM RST
- iLocked  in  1  MMCM LOCKED, asynchronous to iClk

Behaviour:
- Reset values: all outputs 0, except oMmcmRst = 0 (MMCM free-running). Internal state is IDLE; counters and synchronizer are cleared.
- iLocked passes through pSyncStages FFs to give wLockS. Only wLockS is used internally.
- IDLE: oAck = iReq. On accept:
  - latch addr, data, mask, and last;
  - set oBusy = 1 and oErrCode = 0;
  - go to RST_ON.
- RST_ON (1 cycle): oMmcmRst = 1; go to RD_REQ. oMmcmRst stays 1 through all states until REL.
- RD_REQ (1 cycle): oDen = 1, oDwe = 0, oDaddr = addr; clear timer; go to RD_WAIT.
- RD_WAIT:
  - On iDrdy: capture rmw = (iDo & mask) | (iData & ~mask); go to WR_REQ.
  - If timer reaches pDrdyTimeout: go to ERR with code 1.
  - An iDrdy arriving in the same cycle as the timeout wins (no error).
- WR_REQ (1 cycle): oDen = 1, oDwe = 1, oDaddr = addr, oDi = rmw; clear timer; go to WR_WAIT.
- WR_WAIT:
  - On iDrdy: if last, go to REL; else go to NEXT.
  - On timeout: go to ERR with code 2.
- NEXT: oAck = iReq. Accept latches new fields and goes straight to RD_REQ, with the MMCM still in reset. No timeout in this state.
- REL (1 cycle): oMmcmRst = 0; clear timer; go to LOCK_WAIT.
- LOCK_WAIT:
  - On wLockS = 1: go to DONE.
  - If timer reaches pLockTimeout: go to ERR with code 3.
- DONE: oDone pulse; go to IDLE; oBusy = 0 in the same cycle.
- ERR: oErr pulse; oMmcmRst = 0; go to IDLE. The error code is held.
- oAck is never asserted outside IDLE and NEXT.
- iDrdy outside RD_WAIT/WR_WAIT is ignored.
- oDen never re-asserts before iDrdy or timeout, so at most one DRP transaction is outstanding.
- Timers are saturating counters, wide enough for the larger timeout; they do not wrap.
- Reset mid-operation:
  - The state machine returns to IDLE immediately and all outputs go to 0.
  - A pending DRP transaction is abandoned.
  - A later iDrdy is ignored.
- DRP timing: oDaddr, oDi, and oDwe are registered and valid in the same cycle as oDen.

Test Plan:
- Single RMW: addr 0x08, iDo 0x1041, mask 0xF000, data 0x0082, last = 1. Required sequence: oMmcmRst rises → read pulse → write pulse with oDi = 0x1082 → oMmcmRst falls → iLocked asserted after 500 cycles → oDone after sync latency, with oBusy falling in the same cycle.
- Burst of 3 registers (last only on the third): oMmcmRst held high continuously across all 3 RMWs. Exactly 3 read and 3 write DEN pulses. One oDone.
- No iDrdy after the read DEN: oErr pulses after 64 cycles, oErrCode = 1, oMmcmRst = 0, oErrCode holds until the next accept.
- iLocked never rises (shortened pLockTimeout = 100): oErr with oErrCode = 3 at cycle 100 after REL.
- iRst asserted during WR_WAIT, then a late iDrdy: all outputs are 0 asynchronously, no oDone/oErr. A new request then completes normally.
- iDrdy in the exact timeout cycle of RD_WAIT: no error, write proceeds.
